// File: rtl/cinco_pkg.sv
// rtl/cinco_pkg.sv - shared FSM state and ALU opcode definitions
// Shared package for the sequential multiplier and its ALU.
package cinco_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DONE   = 3'd2,
    NEG_A  = 3'd3,
    NEG_B  = 3'd4,
    NEG_LO = 3'd5,
    NEG_HI = 3'd6
  } mul_state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit combinational ALU with carry, overflow, negative and zero flags
// One shared adder serves ADD, SUB and SLT; subtraction is a + ~b + 1.
module alu
  import cinco_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alu_control,
  output logic [31:0] result,
  output logic        c,
  output logic        v,
  output logic        n,
  output logic        z
);

  logic        sub;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        arith;

  assign sub   = (alu_control == ALU_SUB) || (alu_control == ALU_SLT);
  assign arith = sub || (alu_control == ALU_ADD);
  assign b_eff = sub ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {32'b0, sub};

  // Select the operation result and derive the flags from the shared adder.
  always_comb begin
    result = '0;
    v      = arith && (a[31] == b_eff[31]) && (sum[31] != a[31]);
    c      = arith && sum[32];
    case (alu_control)
      ALU_ADD: result = sum[31:0];
      ALU_SUB: result = sum[31:0];
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'b0, sum[31] ^ v};
      default: result = '0;
    endcase
    n = result[31];
    z = (result == 32'd0);
  end

endmodule

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - 32x32 shift-add sequential multiplier built around one shared ALU
// Optional signed operation is enabled by defining MUL_SIGNED_EN (adds the signo port
// and the NEG_A/NEG_B/NEG_LO/NEG_HI sign-fixup states).
module alu_mul_seq
  import cinco_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
`ifdef MUL_SIGNED_EN
  input  logic        signo,
`endif
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  mul_state_t  state;
  logic [31:0] mcand;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [4:0]  count;

`ifdef MUL_SIGNED_EN
  logic        sgn;
  logic        neg;
  logic        lo_c;
`endif

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_c;
  logic        alu_v_unused;
  logic        alu_n_unused;
  logic        alu_z_unused;

  assign product = {hi, lo};

  alu u_alu (
    .a           (alu_a),
    .b           (alu_b),
    .alu_control (alu_control),
    .result      (alu_result),
    .c           (alu_c),
    .v           (alu_v_unused),
    .n           (alu_n_unused),
    .z           (alu_z_unused)
  );

  // Steer the ALU operands per state; idle/done states present zeros with ADD.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = ALU_ADD;
    case (state)
      RUN: begin
        alu_a = hi;
        alu_b = lo[0] ? mcand : 32'd0;
      end
`ifdef MUL_SIGNED_EN
      NEG_A: begin
        alu_control = ALU_SUB;
        alu_b       = mcand;
      end
      NEG_B: begin
        alu_control = ALU_SUB;
        alu_b       = lo;
      end
      NEG_LO: begin
        alu_control = ALU_SUB;
        alu_b       = lo;
      end
      NEG_HI: begin
        if (lo_c) begin
          alu_control = ALU_SUB;
          alu_b       = hi;
        end else begin
          alu_a       = ~hi;
        end
      end
`endif
      default: ;
    endcase
  end

  // Multiplier FSM: accept, optional operand negation, 32 shift-add steps, optional result negation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      count <= '0;
`ifdef MUL_SIGNED_EN
      sgn   <= 1'b0;
      neg   <= 1'b0;
      lo_c  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= op_a;
            lo    <= op_b;
            hi    <= '0;
            count <= '0;
            busy  <= 1'b1;
`ifdef MUL_SIGNED_EN
            sgn   <= signo;
            neg   <= signo & (op_a[31] ^ op_b[31]);
            state <= signo ? NEG_A : RUN;
`else
            state <= RUN;
`endif
          end
        end
        RUN: begin
          // 65-bit {carry, sum, lo} shifted right by one, low 64 bits kept.
          hi    <= {alu_c, alu_result[31:1]};
          lo    <= {alu_result[0], lo[31:1]};
          count <= count + 5'd1;
          if (count == 5'd31) begin
`ifdef MUL_SIGNED_EN
            state <= sgn ? NEG_LO : DONE;
            done  <= !sgn;
`else
            state <= DONE;
            done  <= 1'b1;
`endif
          end
        end
`ifdef MUL_SIGNED_EN
        NEG_A: begin
          if (mcand[31]) mcand <= alu_result;
          state <= NEG_B;
        end
        NEG_B: begin
          if (lo[31]) lo <= alu_result;
          state <= RUN;
        end
        NEG_LO: begin
          // Borrow-free carry out means lo was zero, so the negation ripples into hi.
          if (neg) begin
            lo   <= alu_result;
            lo_c <= alu_c;
          end
          state <= NEG_HI;
        end
        NEG_HI: begin
          if (neg) hi <= alu_result;
          state <= DONE;
          done  <= 1'b1;
        end
`endif
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - self-checking bench for alu_mul_seq (table, random and corner sequences)
module tb_alu_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        signo;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int tests;
  int fails;

  alu_mul_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
`ifdef MUL_SIGNED_EN
    .signo   (signo),
`endif
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa;
    longint sb;
    logic [63:0] ua;
    logic [63:0] ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Called right after driving start at a falling edge; checks latency, busy, single done and result.
  task automatic wait_done(input int exp_lat, input logic [63:0] exp_p, input string name);
    int lat;
    int busy_low;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    busy_low = 0;
    while (!done && lat < 100) begin
      if (!busy) busy_low++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_busy_low_cycles"}, 64'(busy_low), 64'd0);
    chk({name, "_product"}, product, exp_p);
    chk({name, "_busy_in_done"}, {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1;
    chk({name, "_done_pulse"}, {62'd0, busy, done}, 64'd0);
  endtask

  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int exp_lat, input logic [63:0] exp_p, input string name);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    signo = s;
    start = 1'b1;
    wait_done(exp_lat, exp_p, name);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [63:0] rexp;

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    signo = 1'b0;

    tbl[0] = '{32'd7,          32'd6,          64'd42};
    tbl[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE_00000001};
    tbl[2] = '{32'd0,          32'hFFFFFFFF,   64'd0};
    tbl[3] = '{32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF};
    tbl[4] = '{32'd3,          32'd5,          64'd15};
    tbl[5] = '{32'h80000000,   32'd2,          64'h00000001_00000000};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_product", product, 64'd0);

    // Start presented on the very first rising edge after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    op_a  = 32'd7;
    op_b  = 32'd6;
    start = 1'b1;
    wait_done(32, 64'd42, "first_edge_7x6");

    for (int i = 0; i < 6; i++) begin
      do_mul(tbl[i].a, tbl[i].b, 1'b0, 32, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // Start held high through RUN with different operands must not disturb the result.
    @(negedge clk);
    op_a  = 32'd7;
    op_b  = 32'd6;
    signo = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    op_a = 32'd9;
    op_b = 32'd11;
    lat = 0;
    pulses = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("held_start_latency", 64'(lat), 64'd32);
    chk("held_start_product", product, 64'd42);
    @(posedge clk);
    #1;
    chk("held_start_idle", {62'd0, busy, done}, 64'd0);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("held_start_no_extra_done", 64'(pulses), 64'd0);
    chk("held_start_stays_idle", {63'd0, busy}, 64'd0);

    // Reset asserted mid-RUN clears everything at once; a fresh start then works.
    @(negedge clk);
    op_a  = 32'h12345678;
    op_b  = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", {63'd0, busy}, 64'd0);
    chk("midrun_reset_done", {63'd0, done}, 64'd0);
    chk("midrun_reset_product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op_a  = 32'd3;
    op_b  = 32'd5;
    start = 1'b1;
    wait_done(32, 64'd15, "after_reset_3x5");

`ifdef MUL_SIGNED_EN
    do_mul(32'hFFFFFFFD, 32'd5, 1'b1, 36, 64'hFFFFFFFF_FFFFFFF1, "signed_m3x5");
    do_mul(32'h80000000, 32'h80000000, 1'b1, 36, 64'h40000000_00000000, "signed_min_sq");
    do_mul(32'd0, 32'hFFFFFFFF, 1'b1, 36, 64'd0, "signed_0xm1");
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32, 64'hFFFFFFFE_00000001, "signo0_max");
`endif

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 0) ra = 32'hFFFFFFFF;
      if (i % 6 == 1) rb = 32'd0;
      if (i % 6 == 2) rb = 32'h80000000;
`ifdef MUL_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      rexp = model(ra, rb, rs);
      do_mul(ra, rb, rs, rs ? 36 : 32, rexp, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1 bit, multiply request; sampled only in IDLE.
REQ-004 SHALL have port op_a, input, 32 bits, multiplicand; captured on the accepting edge.
REQ-005 SHALL have port op_b, input, 32 bits, multiplier; captured on the accepting edge.
REQ-006 SHALL have port signo, input, 1 bit, 1 = signed two's-complement operands; present only under MUL_SIGNED_EN.
REQ-007 SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-008 SHALL have port done, output, 1 bit, one-cycle pulse, high exactly while in DONE.
REQ-009 SHALL have port product, output, 64 bits, {hi,lo} result; stable from done until the next accepted start.

Function
REQ-010 SHALL implement the FSM states IDLE, RUN and DONE, plus NEG_A, NEG_B, NEG_LO and NEG_HI under MUL_SIGNED_EN.
REQ-011 SHALL, in IDLE with start=1 on an edge, load mcand<=op_a, lo<=op_b, hi<=0, count<=0 and go to RUN (or NEG_A when signed).
REQ-012 SHALL ignore start whenever busy=1; the running operation and its operands are unaffected.
REQ-013 SHALL perform all arithmetic through the single internal alu instance: no other adder in the block.
REQ-014 SHALL, each RUN cycle, drive alu a=hi, b=(lo[0] ? mcand : 0), alu_control=3'b000, and on the edge load {hi,lo} <= {c, result, lo} >> 1 (33-bit carry-in shift).
REQ-015 SHALL count RUN cycles with a 5-bit counter; after the 32nd iteration (count wraps 31->0), go to DONE (or NEG_LO when signed).
REQ-016 SHALL go from DONE to IDLE unconditionally on the next edge; a start present during DONE is not accepted.
REQ-017 SHALL make unsigned latency exactly 32 cycles: done is high in the cycle following the 32nd edge after the accepting edge.
REQ-018 SHALL produce product = op_a * op_b modulo 2^64 for unsigned operation, including operands 0 and 32'hFFFFFFFF.
REQ-019 SHALL drive alu a=0, b=0, alu_control=3'b000 in IDLE and DONE.

Reset
REQ-020 SHALL, on rst_n=0 (at any time, including mid-RUN), immediately force state=IDLE, busy=0, done=0, product=0, count=0, mcand=0 and the sign flag=0.
REQ-021 SHALL accept a start on the first rising edge at which rst_n is high.

Configuration
REQ-022 SHALL, with MUL_SIGNED_EN defined, provide the signo port; when signo=1 on accept, record neg = op_a[31]^op_b[31].
REQ-023 SHALL, with MUL_SIGNED_EN, take NEG_A and NEG_B first: each replaces a negative operand with 0-x (alu_control=3'b001, a=0); a non-negative operand passes unchanged.
REQ-024 SHALL, with MUL_SIGNED_EN and neg=1, take NEG_LO: lo <= 0-lo via 3'b001, saving c; then NEG_HI: hi <= 0-hi via 3'b001 if c=1, else hi <= ~hi via 3'b000 with b=0; with neg=0 both states hold values.
REQ-025 SHALL, with MUL_SIGNED_EN, give a fixed latency of 36 cycles when signo=1 and 32 cycles when signo=0.
REQ-026 SHALL, without MUL_SIGNED_EN, omit the signo port and the NEG_* states; operation is always unsigned.

Structure
REQ-027 SHALL place the FSM state enum and the ALU opcode constants (ADD=3'b000, SUB=3'b001, AND=3'b010, OR=3'b011, SLT=3'b101) in the shared package cinco_pkg.
REQ-028 SHALL instantiate the existing alu module as its only sub-module; the v, n and z flags are left unused.

Verification
REQ-029 SHALL cover: op_a=7, op_b=6, start -> done after 32 cycles, product=64'd42, busy high for cycles 1..32.
REQ-030 SHALL cover: op_a=op_b=32'hFFFFFFFF unsigned -> product=64'hFFFFFFFE_00000001.
REQ-031 SHALL cover: start held high during RUN with different operands -> first result unchanged, single done pulse, IDLE afterwards.
REQ-032 SHALL cover: rst_n pulsed low at RUN count 10 -> busy=0, product=0 immediately; a new start 3*5 -> product=15.
REQ-033 SHALL cover: (MUL_SIGNED_EN) signo=1, op_a=-3, op_b=5 -> done at 36 cycles, product=64'hFFFFFFFF_FFFFFFF1; op_a=32'h80000000, op_b=32'h80000000 -> product=64'h40000000_00000000.
